syscall_seg_display: RTL and testbench

//   Consumer end of the CPU's syscall display path. Captures the 32-bit value
//   the CPU publishes on a syscall (display strobe + data), plus the halt flag.

---
 rtl/seg_pkg.sv | 12 +
 rtl/hex_to_seg.sv | 13 +
 rtl/syscall_seg_display.sv | 86 ++++++++
 tb/tb_syscall_seg_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants: blank pattern and active-low hex glyph table ({g,f,e,d,c,b,a}).
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the glyph for hex digit n; listed from F down to 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_TABLE[hex];
    end

endmodule

// File: rtl/syscall_seg_display.sv
// Captures the CPU syscall display value and halt flag, and scans it in hex
// across a multiplexed active-low common-anode 7-segment bank.
module syscall_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned SCAN_DIV      = 4,
    parameter int unsigned BLANK_LEADING = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_we,
    input  logic [31:0]       disp_data,
    input  logic              halt,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [31:0]       shown
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIG_W-1:0]  digit;
    logic              halt_seen;

    logic [31:0]       shown_next;
    logic              halt_seen_next;
    logic [3:0]        nibble;
    logic [DIGITS-1:0] an_next;
    logic              nonzero_above;
    logic              blank_c;
    logic [6:0]        glyph_c;

    // Select the active nibble and decide blanking from the value being written this edge
    always_comb begin
        shown_next     = disp_we ? disp_data : shown;
        halt_seen_next = halt_seen | halt;
        nibble         = 4'h0;
        an_next        = '1;
        nonzero_above  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit == DIG_W'(i)) begin
                nibble     = shown_next[4*i +: 4];
                an_next[i] = 1'b0;
            end
            if ((DIG_W'(i) >= digit) && (shown_next[4*i +: 4] != 4'h0)) begin
                nonzero_above = 1'b1;
            end
        end
        blank_c = (BLANK_LEADING != 0) && (digit != '0) && !nonzero_above;
    end

    hex_to_seg u_hex_to_seg (
        .hex   (nibble),
        .seg_c (glyph_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit     <= '0;
            halt_seen <= 1'b0;
            shown     <= '0;
            an        <= '1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            shown     <= shown_next;
            halt_seen <= halt_seen_next;
            // Free-running scan: strobes never disturb the prescaler phase
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                digit   <= (digit == DIG_W'(DIGITS - 1)) ? '0 : digit + DIG_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            an  <= an_next;
            seg <= blank_c ? SEG_BLANK : glyph_c;
            dp  <= ~halt_seen_next;
        end
    end

endmodule

// File: tb/tb_syscall_seg_display.sv
// Directed bench for syscall_seg_display: default, no-blanking and 4-digit/fast-scan instances.
module tb_syscall_seg_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_we;
    logic [31:0] disp_data;
    logic        halt;

    logic [7:0]  an8,    an_nb;
    logic [3:0]  an4;
    logic [6:0]  seg8,   seg_nb, seg4;
    logic        dp8,    dp_nb,  dp4;
    logic [31:0] shown8, shown_nb, shown4;

    syscall_seg_display dut (
        .clk(clk), .rst(rst), .disp_we(disp_we), .disp_data(disp_data), .halt(halt),
        .an(an8), .seg(seg8), .dp(dp8), .shown(shown8)
    );

    syscall_seg_display #(.BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .disp_we(disp_we), .disp_data(disp_data), .halt(halt),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .shown(shown_nb)
    );

    syscall_seg_display #(.DIGITS(4), .SCAN_DIV(1)) dut4 (
        .clk(clk), .rst(rst), .disp_we(disp_we), .disp_data(disp_data), .halt(halt),
        .an(an4), .seg(seg4), .dp(dp4), .shown(shown4)
    );

    always #5 clk = ~clk;

    // Post-reset edge count; the output after edge k shows digit ((k-1)/SCAN_DIV) % DIGITS
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int d8();
        return ((cyc - 1) / 4) % 8;
    endfunction

    function automatic int d4();
        return (cyc - 1) % 4;
    endfunction

    task automatic chk_an();
        logic [7:0] e8;
        logic [3:0] e4;
        e8 = ~(8'h01 << d8());
        e4 = ~(4'h1 << d4());
        chk("an8", 32'(an8), 32'(e8));
        chk("an_nb", 32'(an_nb), 32'(e8));
        chk("an4", 32'(an4), 32'(e4));
    endtask

    task automatic chk_reset();
        chk("rst_an8", 32'(an8), 32'hFF);
        chk("rst_an4", 32'(an4), 32'hF);
        chk("rst_seg8", 32'(seg8), 32'h7F);
        chk("rst_dp8", 32'(dp8), 32'h1);
        chk("rst_shown8", shown8, 32'h0);
        chk("rst_shown4", shown4, 32'h0);
    endtask

    typedef struct {
        logic [31:0]     data;
        logic [7:0][6:0] s8;
        logic [7:0][6:0] nb;
        logic [3:0][6:0] s4;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Expected glyphs listed digit7..digit0 (digit3..digit0 for the 4-digit instance)
        vecs[0] = '{32'h89ABCDEF,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[1] = '{32'h000000A0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40},
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40},
                    {7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[2] = '{32'h00000000,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{32'h00102000,
                    {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h40, 7'h40},
                    {7'h40, 7'h40, 7'h79, 7'h40, 7'h24, 7'h40, 7'h40, 7'h40},
                    {7'h24, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{32'h12345678,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00},
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00},
                    {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[5] = '{32'hFFFF1234,
                    {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h79, 7'h24, 7'h30, 7'h19},
                    {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h79, 7'h24, 7'h30, 7'h19},
                    {7'h79, 7'h24, 7'h30, 7'h19}};

        // Reset held 3 cycles with a strobe pending
        rst = 1'b1; disp_we = 1'b1; disp_data = 32'h12345678; halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset();
        end
        rst = 1'b0; disp_we = 1'b0;
        tick();
        chk("first_an8", 32'(an8), 32'hFE);
        chk("first_seg8", 32'(seg8), 32'h40);
        chk("first_an4", 32'(an4), 32'hE);
        chk("first_seg4", 32'(seg4), 32'h40);
        tick();

        // Each vector: one-cycle strobe, then a full 8-digit scan on every instance
        for (int v = 0; v < 6; v++) begin
            disp_data = vecs[v].data;
            disp_we   = 1'b1;
            tick();
            disp_we   = 1'b0;
            for (int c = 0; c < 32; c++) begin
                chk_an();
                chk("shown8", shown8, vecs[v].data);
                chk("shown4", shown4, vecs[v].data);
                chk("seg8", 32'(seg8), 32'(vecs[v].s8[d8()]));
                chk("seg_nb", 32'(seg_nb), 32'(vecs[v].nb[d8()]));
                chk("seg4", 32'(seg4), 32'(vecs[v].s4[d4()]));
                chk("dp8", 32'(dp8), 32'h1);
                tick();
            end
        end

        // Halt pulse mid-scan: dp goes low next cycle and stays low
        for (int i = 0; i < 5; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int c = 0; c < 40; c++) begin
            chk_an();
            chk("halt_dp8", 32'(dp8), 32'h0);
            chk("halt_dp4", 32'(dp4), 32'h0);
            chk("halt_seg8", 32'(seg8), 32'(vecs[5].s8[d8()]));
            tick();
        end

        // Reset with a simultaneous strobe: reset wins, dp returns high
        rst = 1'b1; disp_we = 1'b1; disp_data = 32'h1;
        tick();
        chk_reset();
        chk("rst_dp4", 32'(dp4), 32'h1);
        rst = 1'b0; disp_we = 1'b0;
        tick();
        chk("post_rst_dp8", 32'(dp8), 32'h1);
        chk("post_rst_shown8", shown8, 32'h0);
        chk_an();

        // Back-to-back strobes mid-scan: last wins, scan phase undisturbed
        for (int i = 0; i < 6; i++) tick();
        disp_data = 32'h5; disp_we = 1'b1;
        tick();
        chk("b2b_shown_first", shown8, 32'h5);
        chk_an();
        disp_data = 32'h6;
        tick();
        disp_we = 1'b0;
        for (int c = 0; c < 34; c++) begin
            chk_an();
            chk("b2b_shown8", shown8, 32'h6);
            chk("b2b_shown4", shown4, 32'h6);
            chk("b2b_seg8", 32'(seg8), (d8() == 0) ? 32'h02 : 32'h7F);
            chk("b2b_seg_nb", 32'(seg_nb), (d8() == 0) ? 32'h02 : 32'h40);
            chk("b2b_seg4", 32'(seg4), (d4() == 0) ? 32'h02 : 32'h7F);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
